pll_ddr_ctrl: RTL and testbench

Sequencing and dynamic-adjust controller for the DDR clocking rPLL. It sits directly upstream of the PLL wrapper: it drives the PLL reset and its dynamic phase (psda), duty (dutyda) and fine-delay (fdly) inputs, monitors lock, and retries on lock timeout. It presents a single `ready` qualifier that releases the downstream DDR logic. It runs on the PLL reference clock because the PLL output is not trustworthy until lock.

---
 rtl/pll_ddr_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pll_ddr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_ddr_ctrl.sv
// pll_ddr_ctrl
//   Bring-up and dynamic-adjust sequencer for the DDR clocking rPLL. Runs on
//   the PLL reference clock. It pulses the PLL reset, waits for lock with a
//   timeout and bounded retries, requires a run of consecutive locked cycles
//   before raising `ready`, and applies new phase/duty/fine-delay settings
//   through a valid/ready handshake followed by a settle hold-off.
//
// Ports
//   clkin                 reference clock (same net as the PLL input)
//   reset_n               synchronous active-low reset
//   pll_lock              PLL lock, asynchronous, synchronized internally
//   pll_reset             PLL reset, active high
//   psda/dutyda/fdly      dynamic phase / duty / fine-delay to the PLL
//   cfg_valid/cfg_ready   handshake for a new setting
//   cfg_psda/dutyda/fdly  offered setting
//   ready                 PLL locked and settled, releases downstream logic
//   fail                  lock retries exhausted (sticky until reset_n)
//   relock_cnt            lock losses seen after reaching RUN, saturating

module pll_ddr_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clkin,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    output logic [3:0] fdly,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    input  logic [3:0] cfg_fdly,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_cnt
);

    // One shared phase counter, wide enough for the largest interval.
    localparam int MAX_RS  = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1);

    // Terminal values: the counter starts at 0 on state entry, so the
    // transition fires on the edge where it already holds P-1.
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SET_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_RST, S_WAIT, S_SETTLE, S_RUN, S_APL, S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          lock_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n;
    logic [3:0]    psda_n, dutyda_n, fdly_n;
    logic [7:0]    relock_n;
    logic          hs;

    assign lock_s = sync[1];

    // Lock loss masks the handshake in the same cycle, so a setting is never
    // taken while the state machine is heading back to RST.
    assign cfg_ready = (state == S_RUN) && lock_s;
    assign hs        = cfg_valid && cfg_ready;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        retry_n  = retry;
        psda_n   = psda;
        dutyda_n = dutyda;
        fdly_n   = fdly;
        relock_n = relock_cnt;
        case (state)
            S_RST: begin
                if (cnt == RST_LAST) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    retry_n = retry + 1'b1;
                    cnt_n   = '0;
                    state_n = (retry == RETRY_LAST) ? S_FAIL : S_RST;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else if (cnt == SET_LAST) begin
                    state_n = S_RUN;
                    retry_n = '0;
                    cnt_n   = '0;
                end
            end
            S_RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    if (relock_cnt != 8'hFF) relock_n = relock_cnt + 8'd1;
                    state_n = S_RST;
                end else if (hs) begin
                    psda_n   = cfg_psda;
                    dutyda_n = cfg_dutyda;
                    fdly_n   = cfg_fdly;
                    state_n  = S_APL;
                end
            end
            S_APL: begin
                if (!lock_s) begin
                    if (relock_cnt != 8'hFF) relock_n = relock_cnt + 8'd1;
                    state_n = S_RST;
                    cnt_n   = '0;
                end else if (cnt == SET_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end
            end
            S_FAIL: begin
                cnt_n = cnt;
            end
            default: begin
                state_n = S_RST;
                cnt_n   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            state      <= S_RST;
            sync       <= 2'b00;
            cnt        <= '0;
            retry      <= '0;
            psda       <= 4'b0000;
            dutyda     <= 4'b1000;
            fdly       <= 4'b0000;
            relock_cnt <= 8'd0;
            pll_reset  <= 1'b1;
            ready      <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_n;
            sync       <= {sync[0], pll_lock};
            cnt        <= cnt_n;
            retry      <= retry_n;
            psda       <= psda_n;
            dutyda     <= dutyda_n;
            fdly       <= fdly_n;
            relock_cnt <= relock_n;
            pll_reset  <= (state_n == S_RST) || (state_n == S_FAIL);
            ready      <= (state_n == S_RUN);
            fail       <= (state_n == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_ddr_ctrl.sv
// tb_pll_ddr_ctrl
//   Bench for pll_ddr_ctrl. `dut` uses default timing and is tracked by a
//   deadline-based reference model; `dut_to` uses a short lock timeout with
//   lock held low and is checked against a closed-form retry schedule.

module tb_pll_ddr_ctrl;

    localparam int RSTC = 16;
    localparam int LTO  = 65535;
    localparam int SETC = 8;
    localparam int MAXR = 3;
    localparam int TO2  = 50;

    localparam int M_RST = 0, M_WAIT = 1, M_SET = 2, M_RUN = 3, M_APL = 4, M_FAIL = 5;

    logic clkin = 1'b0;
    always #20 clkin = ~clkin;

    logic       reset_n, pll_lock, cfg_valid;
    logic [3:0] cfg_psda, cfg_dutyda, cfg_fdly;
    logic       pll_reset, cfg_ready, ready, fail;
    logic [3:0] psda, dutyda, fdly;
    logic [7:0] relock_cnt;

    logic       rst2_n, pll_reset2, cfg_ready2, ready2, fail2;
    logic [3:0] psda2, dutyda2, fdly2;
    logic [7:0] relock2;

    pll_ddr_ctrl #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(LTO), .SETTLE_CYCLES(SETC), .MAX_RETRY(MAXR)) dut (
        .clkin(clkin), .reset_n(reset_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .psda(psda), .dutyda(dutyda), .fdly(fdly),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_psda(cfg_psda), .cfg_dutyda(cfg_dutyda), .cfg_fdly(cfg_fdly),
        .ready(ready), .fail(fail), .relock_cnt(relock_cnt)
    );

    pll_ddr_ctrl #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO2), .SETTLE_CYCLES(SETC), .MAX_RETRY(MAXR)) dut_to (
        .clkin(clkin), .reset_n(rst2_n), .pll_lock(1'b0), .pll_reset(pll_reset2),
        .psda(psda2), .dutyda(dutyda2), .fdly(fdly2),
        .cfg_valid(1'b0), .cfg_ready(cfg_ready2),
        .cfg_psda(4'd0), .cfg_dutyda(4'd0), .cfg_fdly(4'd0),
        .ready(ready2), .fail(fail2), .relock_cnt(relock2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: mode plus absolute-cycle deadlines.
    int         m_mode, m_dl, m_tries, m_relock;
    logic       m_s1, m_ls;
    logic [3:0] m_ps, m_du, m_fd;

    task automatic model_edge();
        logic ls;
        ls = m_ls;
        if (!reset_n) begin
            m_mode = M_RST; m_dl = cyc + RSTC; m_tries = 0; m_relock = 0;
            m_s1 = 1'b0; m_ls = 1'b0; m_ps = 4'd0; m_du = 4'd8; m_fd = 4'd0;
        end else begin
            case (m_mode)
                M_RST: if (cyc == m_dl) begin m_mode = M_WAIT; m_dl = cyc + LTO; end
                M_WAIT: begin
                    if (ls) begin m_mode = M_SET; m_dl = cyc + SETC; end
                    else if (cyc == m_dl) begin
                        m_tries++;
                        if (m_tries == MAXR) m_mode = M_FAIL;
                        else begin m_mode = M_RST; m_dl = cyc + RSTC; end
                    end
                end
                M_SET: begin
                    if (!ls) begin m_mode = M_WAIT; m_dl = cyc + LTO; end
                    else if (cyc == m_dl) begin m_mode = M_RUN; m_tries = 0; end
                end
                M_RUN, M_APL: begin
                    if (!ls) begin
                        m_relock = (m_relock < 255) ? m_relock + 1 : 255;
                        m_mode = M_RST; m_dl = cyc + RSTC;
                    end else if (m_mode == M_RUN && cfg_valid) begin
                        m_ps = cfg_psda; m_du = cfg_dutyda; m_fd = cfg_fdly;
                        m_mode = M_APL; m_dl = cyc + SETC;
                    end else if (m_mode == M_APL && cyc == m_dl) begin
                        m_mode = M_RUN;
                    end
                end
                default: ;
            endcase
            m_ls = m_s1;
            m_s1 = pll_lock;
        end
    endtask

    function automatic logic [23:0] dut_vec();
        return {pll_reset, ready, fail, cfg_ready, psda, dutyda, fdly, relock_cnt};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {(m_mode == M_RST) || (m_mode == M_FAIL), m_mode == M_RUN, m_mode == M_FAIL,
                (m_mode == M_RUN) && m_ls, m_ps, m_du, m_fd, m_relock[7:0]};
    endfunction

    // Advance one clock: model follows the edge, outputs are read at negedge.
    task automatic step();
        @(posedge clkin);
        cyc++;
        model_edge();
        @(negedge clkin);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rst2_n = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0;
        cfg_psda = 4'd0; cfg_dutyda = 4'd0; cfg_fdly = 4'd0;
        step(); step();
        checks++;
        if ({pll_reset, ready, fail, cfg_ready} !== 4'b1000) begin
            errors++; $display("FAIL reset_status got=%b exp=1000", {pll_reset, ready, fail, cfg_ready});
        end
        checks++;
        if ({psda, dutyda, fdly, relock_cnt} !== 20'h08000) begin
            errors++; $display("FAIL reset_values got=%h exp=08000", {psda, dutyda, fdly, relock_cnt});
        end
        checks++;
        if ({pll_reset2, ready2, fail2, cfg_ready2, dutyda2, relock2} !== 16'h8800) begin
            errors++; $display("FAIL reset_dut_to got=%h exp=8800", {pll_reset2, ready2, fail2, cfg_ready2, dutyda2, relock2});
        end
    endtask

    task automatic test_timeout();
        int   c0, c, per;
        logic er, ef;
        per = RSTC + TO2;
        c0 = cyc;
        rst2_n = 1'b1;
        for (int i = 1; i <= 3 * per + 60; i++) begin
            step();
            c  = cyc - c0;
            ef = (c >= 3 * per);
            er = ef || ((c % per) < RSTC);
            checks++;
            if (pll_reset2 !== er || fail2 !== ef || ready2 !== 1'b0) begin
                errors++;
                $display("FAIL timeout_seq c=%0d got pll_reset=%b fail=%b ready=%b exp pll_reset=%b fail=%b ready=0",
                         c, pll_reset2, fail2, ready2, er, ef);
            end
        end
        rst2_n = 1'b0;
        step();
        checks++;
        if ({pll_reset2, fail2} !== 2'b10) begin
            errors++; $display("FAIL timeout_exit_reset got=%b exp=10", {pll_reset2, fail2});
        end
    endtask

    task automatic test_bringup();
        int first_low = -1, first_ready = -1;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            pll_lock = (i >= 100);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL bringup_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (first_low < 0 && pll_reset === 1'b0) first_low = i;
            if (first_ready < 0 && ready === 1'b1) first_ready = i;
        end
        checks++;
        if (first_low != RSTC) begin errors++; $display("FAIL bringup_rst_len got=%0d exp=%0d", first_low, RSTC); end
        checks++;
        if (first_ready != 100 + 2 + SETC) begin
            errors++; $display("FAIL bringup_ready_cycle got=%0d exp=%0d", first_ready, 100 + 2 + SETC);
        end
        checks++;
        if ({psda, dutyda, fdly} !== 12'h080) begin
            errors++; $display("FAIL bringup_defaults got=%h exp=080", {psda, dutyda, fdly});
        end
    endtask

    task automatic test_config();
        int low = 0;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL config_cfg_ready got=%b exp=1", cfg_ready); end
        cfg_valid = 1'b1; cfg_psda = 4'd5; cfg_dutyda = 4'd4; cfg_fdly = 4'd3;
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({psda, dutyda, fdly, ready} !== {12'h543, 1'b0}) begin
            errors++; $display("FAIL config_apply got=%h exp=a86", {psda, dutyda, fdly, ready});
        end
        while (ready !== 1'b1 && low < 20) begin
            low++; step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL config_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (low != SETC) begin errors++; $display("FAIL config_ready_low got=%0d exp=%0d", low, SETC); end
    endtask

    task automatic test_lock_loss();
        int hi = 0, n = 0;
        bit seen_low = 1'b0;
        pll_lock = 1'b0; step(); pll_lock = 1'b1;
        while (n < 80 && !(seen_low && ready === 1'b1)) begin
            step(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL lockloss_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (ready === 1'b0) seen_low = 1'b1;
            if (pll_reset === 1'b1) hi++;
        end
        checks++;
        if (n >= 80) begin errors++; $display("FAIL lockloss_relock got=timeout exp=ready"); end
        checks++;
        if (hi != RSTC) begin errors++; $display("FAIL lockloss_rst_len got=%0d exp=%0d", hi, RSTC); end
        checks++;
        if ({psda, dutyda, fdly, relock_cnt} !== 20'h54301) begin
            errors++; $display("FAIL lockloss_retain got=%h exp=54301", {psda, dutyda, fdly, relock_cnt});
        end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        pll_lock = 1'b0; step(); pll_lock = 1'b1; step();
        cfg_valid = 1'b1; cfg_psda = 4'd9; cfg_dutyda = 4'd2; cfg_fdly = 4'd7;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL simul_cfg_ready got=%b exp=0", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({pll_reset, ready, psda, dutyda, fdly, relock_cnt} !== {2'b10, 12'h543, 8'd2}) begin
            errors++; $display("FAIL simul_no_transfer got=%h exp=%h",
                               {pll_reset, ready, psda, dutyda, fdly, relock_cnt}, {2'b10, 12'h543, 8'd2});
        end
        while (n < 80 && ready !== 1'b1) begin
            step(); n++;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL simul_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midreset();
        cfg_valid = 1'b1;
        cfg_psda = 4'($urandom_range(1, 15)); cfg_dutyda = 4'($urandom_range(0, 7)); cfg_fdly = 4'($urandom_range(1, 15));
        step(); cfg_valid = 1'b0; step(); step();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midreset_in_apl got ready=%b exp=0", ready); end
        reset_n = 1'b0; step(); reset_n = 1'b1;
        checks++;
        if ({pll_reset, ready, fail, cfg_ready, psda, dutyda, fdly, relock_cnt} !== 24'h808000) begin
            errors++; $display("FAIL midreset_values got=%h exp=808000",
                               {pll_reset, ready, fail, cfg_ready, psda, dutyda, fdly, relock_cnt});
        end
    endtask

    task automatic test_settle_glitch();
        int first_ready = -1;
        reset_n = 1'b0; pll_lock = 1'b0; step(); reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        for (int i = 0; i <= 24; i++) begin
            pll_lock = (i != 8);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
            if (first_ready < 0 && ready === 1'b1) first_ready = i;
        end
        checks++;
        if (first_ready != 19) begin errors++; $display("FAIL glitch_ready_cycle got=%0d exp=19", first_ready); end
    endtask

    task automatic test_saturate();
        int  n, ev;
        bit  seen_low;
        for (int k = 0; k < 300; k++) begin
            pll_lock = 1'b0; step(); pll_lock = 1'b1;
            n = 0; seen_low = 1'b0;
            while (n < 80 && !(seen_low && ready === 1'b1)) begin
                step(); n++;
                if (ready === 1'b0) seen_low = 1'b1;
            end
            ev = (k + 1 > 255) ? 255 : k + 1;
            checks++;
            if (n >= 80 || relock_cnt !== 8'(ev)) begin
                errors++; $display("FAIL saturate_k%0d got relock=%0d n=%0d exp relock=%0d", k, relock_cnt, n, ev);
            end
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL saturate_model got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pll_lock   = ($urandom_range(0, 99) >= 2);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_psda   = 4'($urandom); cfg_dutyda = 4'($urandom); cfg_fdly = 4'($urandom);
            reset_n    = ($urandom_range(0, 499) != 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        reset_n = 1'b1; cfg_valid = 1'b0;
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog cyc=%0d exp=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_timeout();
        test_bringup();
        test_config();
        test_lock_loss();
        test_simultaneous();
        test_midreset();
        test_settle_glitch();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
